// File: rtl/pwm_axi_regs_if.sv
// AXI4-Lite bus bundle between the processor-side master and the pwm register slave.
// Signal names follow the S00_AXI port names of the pwm IP.
interface pwm_axi_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/pwm_axi_regs.sv
// AXI4-Lite slave with four read/write registers (CTRL, PERIOD, DUTY, SCRATCH)
// driving a PWM generator whose period/duty are shadowed and reloaded only on wrap.
module pwm_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  pwm_axi_regs_if.slave        s_axi,
  output logic                 pwm_out
);

  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int SEL_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_REGS  = 2 ** SEL_W;

  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

  localparam int REG_CTRL   = 0;
  localparam int REG_PERIOD = 1;
  localparam int REG_DUTY   = 2;

  // AXI handshake state
  logic  awready_q, awready_d;
  logic  bvalid_q,  bvalid_d;
  logic  arready_q, arready_d;
  logic  rvalid_q,  rvalid_d;
  word_t rdata_q,   rdata_d;

  // Register file and PWM engine state
  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  word_t cnt_q, cnt_d;
  word_t act_period_q, act_period_d;
  word_t act_duty_q, act_duty_d;
  logic  pwm_q, pwm_d;

  logic             wr_accept;
  logic             rd_accept;
  logic [SEL_W-1:0] wr_sel;
  logic [SEL_W-1:0] rd_sel;
  logic             pwm_en;
  logic             wrap;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign wr_sel = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_sel = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // A write needs address and data together, and never overlaps a pending response.
  assign wr_accept = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !awready_q && !bvalid_q;
  assign rd_accept = s_axi.S_AXI_ARVALID && !arready_q && !rvalid_q;

  assign pwm_en = regs_q[REG_CTRL][0];
  assign wrap   = (act_period_q == '0) || (cnt_q == act_period_q - word_t'(1));

  // NOTE: every always_comb output gets a default before any branch, so no path leaves a latch.
  always_comb begin
    awready_d = wr_accept;
    bvalid_d  = bvalid_q;
    regs_d    = regs_q;

    if (awready_q) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (wr_accept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          regs_d[wr_sel][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured from the pre-edge register contents, so a same-cycle write is not seen.
  always_comb begin
    arready_d = rd_accept;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;

    if (rd_accept) begin
      rdata_d = regs_q[rd_sel];
    end

    if (arready_q) begin
      rvalid_d = 1'b1;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // While disabled the shadows track the registers; while running they reload only on wrap.
  always_comb begin
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    pwm_d        = pwm_en && (act_period_q != '0) && (cnt_q < act_duty_q);

    if (!pwm_en || wrap) begin
      cnt_d        = '0;
      act_period_d = regs_q[REG_PERIOD];
      act_duty_d   = regs_q[REG_DUTY];
    end else begin
      cnt_d = cnt_q + word_t'(1);
    end
  end

  // NOTE: the register file is a handful of flops, not a RAM, so it is reset like any other state.
  // NOTE: sequential state uses non-blocking assignments only; next-state logic lives in always_comb.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      regs_q       <= '{default: '0};
      cnt_q        <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      pwm_q        <= 1'b0;
    end else begin
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      regs_q       <= regs_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign pwm_out             = pwm_q;

endmodule
